maxpool_engine: RTL and testbench
=================================

Name: maxpool_engine

Overview:
- Responder for the layer-sequencer max-pooling interface. It latches the mp_* layer descriptor on an mp_start pulse.
- It reads the convolution output feature map from the shared BRAM, computes the signed maximum over each pooling window, and writes the pooled map back to BRAM.
- It signals completion with a one-cycle mp_picture_finish pulse. The sequencer detects the falling edge of that pulse.

Parameters:
- width, 8, data word width (signed fixed point).
- memaddrbit, 20, BRAM address width.

Ports:
- clk input 1 clock
- rst input 1 asynchronous active-low reset
- mp_start input 1 one-cycle start pulse
- mp_di input memaddrbit input channels
- mp_dr input memaddrbit input rows
- mp_dc input memaddrbit input cols
- mp_dkr input memaddrbit window rows
- mp_dkc input memaddrbit window cols
- mp_step input 3 window stride
- mp_di_out input memaddrbit output channels
- mp_dr_out input memaddrbit output rows
- mp_dc_out input memaddrbit output cols
- mp_inaddr input memaddrbit input map base address
- mp_outaddr input memaddrbit output map base address
- mem_rdata input width BRAM read data
- memaddr output memaddrbit BRAM address
- mem_wdata output width BRAM write data
- wea output 1 BRAM write enable
- busy output 1 high from the cycle after mp_start until finish
- mp_picture_finish output 1 completion pulse

Behaviour:
- Reset and clock: reset is rst, asynchronous, active-low; clock is clk.
- Reset values: all outputs 0; state IDLE; all counters 0; accumulator 0x80.
- A reset asserted mid-operation aborts immediately. wea drops asynchronously. No partial-window write occurs.
- Descriptor latching: all mp_* inputs are registered when mp_start is seen in IDLE. Later input changes have no effect until the next start.
- mp_start outside IDLE is ignored.
- Memory layout, channel-major: addr = base + ii*dr*dc + ir*dc + ic. Address products are truncated to memaddrbit.
- BRAM read is synchronous: mem_rdata for the address driven in cycle n is valid in cycle n+1.
- Iteration order: ic_out innermost, then ir_out, then ii. Within a window, ikc innermost, then ikr.
- Input element position: ir = ir_out*step + ikr, ic = ic_out*step + ikc.
- Output address is a running counter starting at mp_outaddr and incrementing by 1 per written result.
- States:
  - IDLE: wait for mp_start.
  - RD: drive the read address; wea=0.
  - CAP: compare mem_rdata as signed against acc; acc <= max. Advance ikc/ikr. Go to RD while window elements remain, otherwise to WR.
  - WR: wea=1 for exactly one cycle; memaddr = output counter; mem_wdata = acc. Reset acc to 0x80. Advance ic_out/ir_out/ii. Go to RD, or to DONE after the last output.
  - DONE: mp_picture_finish=1 for exactly one cycle, busy=0, then IDLE.
- Window clipping (floor mode): elements with ir >= mp_dr or ic >= mp_dc are skipped and take no RD/CAP cycles. A fully clipped window writes 0x80.
- Compare rule: ties keep the current acc. Both operands are compared as two's-complement width bits.
- Latency: with the mp_start cycle as cycle 0, mp_picture_finish is high in cycle 1 + sum over windows of (2*k_eff + 1), where k_eff is the number of unclipped elements in the window.
- Degenerate descriptor: if any of mp_di_out, mp_dr_out, mp_dc_out, mp_dkr or mp_dkc is 0, go straight to DONE. Finish is high in cycle 1 and no writes occur.
- busy: high from cycle 1 through the DONE cycle exclusive. It is low in the same cycle that finish is high.
- wea is never high outside WR. memaddr holds its last value in IDLE.

Test Plan:
- Basic 2x2 pooling:
  - Stimulus: 1 channel, 4x4 map holding 0..15 row-major at address 100; dkr=dkc=2, step=2, dr_out=dc_out=2; output at 200.
  - Required: writes 5,7,13,15 to addresses 200..203 in that order; finish in cycle 37; exactly 4 wea pulses.
- Signed compare:
  - Stimulus: one window containing -3,-7,-1,-128.
  - Required: writes 0xFF (-1). A window of all 0x80 writes 0x80.
- Layer-1 geometry:
  - Stimulus: mp_di=16, dr=dc=30, out 15x15, inaddr 3506, outaddr 17906.
  - Required: 3600 writes covering 17906..21505 contiguously; finish in cycle 32401; finish high exactly one cycle.
- Clipping:
  - Stimulus: 1 channel, 5x5 input, 2x2 window, step 2, out 3x3.
  - Required: the last-column and last-row windows use only the in-bounds elements; the corner window reads 1 element (3 cycles).
- Robustness:
  - Stimulus: mp_start re-pulsed while busy, then rst pulled low mid-window, then restarted.
  - Required: the second start has no effect. On reset all outputs are 0 and wea is 0 immediately. After restart the full correct result is produced.
- Degenerate descriptor:
  - Stimulus: mp_dc_out=0.
  - Required: finish in cycle 1; no wea pulse.

Source files
------------

// File: rtl/maxpool_engine.sv
// Max-pooling responder: reads a channel-major feature map from BRAM and writes the
// signed maximum of every pooling window back to a contiguous output region.
module maxpool_engine #(
    parameter int width      = 8,
    parameter int memaddrbit = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mp_start,
    input  logic [memaddrbit-1:0] mp_di,
    input  logic [memaddrbit-1:0] mp_dr,
    input  logic [memaddrbit-1:0] mp_dc,
    input  logic [memaddrbit-1:0] mp_dkr,
    input  logic [memaddrbit-1:0] mp_dkc,
    input  logic [2:0]            mp_step,
    input  logic [memaddrbit-1:0] mp_di_out,
    input  logic [memaddrbit-1:0] mp_dr_out,
    input  logic [memaddrbit-1:0] mp_dc_out,
    input  logic [memaddrbit-1:0] mp_inaddr,
    input  logic [memaddrbit-1:0] mp_outaddr,
    input  logic [width-1:0]      mem_rdata,
    output logic [memaddrbit-1:0] memaddr,
    output logic [width-1:0]      mem_wdata,
    output logic                  wea,
    output logic                  busy,
    output logic                  mp_picture_finish
);
    typedef logic [memaddrbit-1:0] addr_t;

    // IDLE wait start | RD drive read addr | CAP fold rdata into acc | WR store acc | DONE finish pulse
    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_DONE} state_t;

    localparam logic [width-1:0] ACC_INIT = {1'b1, {(width-1){1'b0}}};
    localparam addr_t            ONE      = addr_t'(1);

    state_t           r_state;
    addr_t            r_dr, r_dc, r_dkr, r_dkc, r_step;
    addr_t            r_di_out, r_dr_out, r_dc_out;
    addr_t            r_plane, r_row_stride;
    addr_t            r_ii, r_ir_out, r_ic_out, r_ikr, r_ikc;
    addr_t            r_kr_eff, r_kc_eff, r_ir0, r_ic0;
    addr_t            r_ch_base, r_row_base, r_win_base, r_elem_row;
    addr_t            r_out_cnt;
    logic [width-1:0] r_acc;
    addr_t            r_memaddr;
    logic [width-1:0] r_wdata;
    logic             r_wea, r_busy, r_finish;

    addr_t            w_step_ext, w_plane, w_row_stride;
    logic             w_degen;
    logic [width-1:0] w_new_acc;
    addr_t            w_nx_ii, w_nx_ir_out, w_nx_ic_out, w_nx_ir0, w_nx_ic0;
    addr_t            w_nx_ch_base, w_nx_row_base, w_nx_win_base, w_nx_out;
    addr_t            w_lim_r, w_lim_c, w_kr, w_kc, w_kr_eff, w_kc_eff;
    logic             w_last, w_empty, w_enter, w_last_c, w_last_r;

    // Number of in-bounds window elements along one axis (floor-mode clipping).
    function automatic addr_t clip_len(input addr_t pos, input addr_t lim, input addr_t k);
        addr_t rem;
        rem = lim - pos;
        if (pos >= lim)
            return '0;
        return (k < rem) ? k : rem;
    endfunction

    assign w_step_ext   = addr_t'(mp_step);
    assign w_plane      = mp_dr * mp_dc;
    assign w_row_stride = mp_dc * w_step_ext;
    // No input planes means nothing to read either.
    assign w_degen      = (mp_di_out == '0) || (mp_dr_out == '0) || (mp_dc_out == '0) ||
                          (mp_dkr == '0) || (mp_dkc == '0) || (mp_di == '0);
    assign w_new_acc    = ($signed(mem_rdata) > $signed(r_acc)) ? mem_rdata : r_acc;
    assign w_last_c     = (r_ikc == r_kc_eff - ONE);
    assign w_last_r     = (r_ikr == r_kr_eff - ONE);

    always_comb begin
        w_nx_ii       = r_ii;
        w_nx_ir_out   = r_ir_out;
        w_nx_ic_out   = r_ic_out + ONE;
        w_nx_ir0      = r_ir0;
        w_nx_ic0      = r_ic0 + r_step;
        w_nx_ch_base  = r_ch_base;
        w_nx_row_base = r_row_base;
        w_nx_win_base = r_win_base + r_step;
        w_nx_out      = r_out_cnt + ONE;
        w_lim_r       = r_dr;
        w_lim_c       = r_dc;
        w_kr          = r_dkr;
        w_kc          = r_dkc;
        w_last        = 1'b0;
        if (r_state == S_IDLE) begin
            w_nx_ii       = '0;
            w_nx_ir_out   = '0;
            w_nx_ic_out   = '0;
            w_nx_ir0      = '0;
            w_nx_ic0      = '0;
            w_nx_ch_base  = mp_inaddr;
            w_nx_row_base = mp_inaddr;
            w_nx_win_base = mp_inaddr;
            w_nx_out      = mp_outaddr;
            w_lim_r       = mp_dr;
            w_lim_c       = mp_dc;
            w_kr          = mp_dkr;
            w_kc          = mp_dkc;
        end else if (r_ic_out == r_dc_out - ONE) begin
            w_nx_ic_out   = '0;
            w_nx_ic0      = '0;
            if (r_ir_out != r_dr_out - ONE) begin
                w_nx_ir_out   = r_ir_out + ONE;
                w_nx_ir0      = r_ir0 + r_step;
                w_nx_row_base = r_row_base + r_row_stride;
                w_nx_win_base = w_nx_row_base;
            end else begin
                w_nx_ir_out   = '0;
                w_nx_ir0      = '0;
                w_nx_ii       = r_ii + ONE;
                w_nx_ch_base  = r_ch_base + r_plane;
                w_nx_row_base = w_nx_ch_base;
                w_nx_win_base = w_nx_ch_base;
                w_last        = (r_ii == r_di_out - ONE);
            end
        end
        w_kr_eff = clip_len(w_nx_ir0, w_lim_r, w_kr);
        w_kc_eff = clip_len(w_nx_ic0, w_lim_c, w_kc);
        w_empty  = (w_kr_eff == '0) || (w_kc_eff == '0);
        w_enter  = ((r_state == S_IDLE) && mp_start && !w_degen) ||
                   ((r_state == S_WR) && !w_last);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_dr         <= '0;
            r_dc         <= '0;
            r_dkr        <= '0;
            r_dkc        <= '0;
            r_step       <= '0;
            r_di_out     <= '0;
            r_dr_out     <= '0;
            r_dc_out     <= '0;
            r_plane      <= '0;
            r_row_stride <= '0;
            r_ii         <= '0;
            r_ir_out     <= '0;
            r_ic_out     <= '0;
            r_ikr        <= '0;
            r_ikc        <= '0;
            r_kr_eff     <= '0;
            r_kc_eff     <= '0;
            r_ir0        <= '0;
            r_ic0        <= '0;
            r_ch_base    <= '0;
            r_row_base   <= '0;
            r_win_base   <= '0;
            r_elem_row   <= '0;
            r_out_cnt    <= '0;
            r_acc        <= ACC_INIT;
            r_memaddr    <= '0;
            r_wdata      <= '0;
            r_wea        <= 1'b0;
            r_busy       <= 1'b0;
            r_finish     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (mp_start) begin
                        r_dr         <= mp_dr;
                        r_dc         <= mp_dc;
                        r_dkr        <= mp_dkr;
                        r_dkc        <= mp_dkc;
                        r_step       <= w_step_ext;
                        r_di_out     <= mp_di_out;
                        r_dr_out     <= mp_dr_out;
                        r_dc_out     <= mp_dc_out;
                        r_plane      <= w_plane;
                        r_row_stride <= w_row_stride;
                        r_out_cnt    <= mp_outaddr;
                        r_acc        <= ACC_INIT;
                        if (w_degen) begin
                            r_state  <= S_DONE;
                            r_finish <= 1'b1;
                        end else begin
                            r_busy   <= 1'b1;
                        end
                    end
                end
                S_RD: begin
                    r_state <= S_CAP;
                end
                S_CAP: begin
                    r_acc <= w_new_acc;
                    if (!w_last_c) begin
                        r_ikc     <= r_ikc + ONE;
                        r_memaddr <= r_elem_row + r_ikc + ONE;
                        r_state   <= S_RD;
                    end else if (!w_last_r) begin
                        r_ikc      <= '0;
                        r_ikr      <= r_ikr + ONE;
                        r_elem_row <= r_elem_row + r_dc;
                        r_memaddr  <= r_elem_row + r_dc;
                        r_state    <= S_RD;
                    end else begin
                        r_wea     <= 1'b1;
                        r_memaddr <= r_out_cnt;
                        r_wdata   <= w_new_acc;
                        r_state   <= S_WR;
                    end
                end
                S_WR: begin
                    r_wea     <= 1'b0;
                    r_acc     <= ACC_INIT;
                    r_out_cnt <= r_out_cnt + ONE;
                    if (w_last) begin
                        r_state  <= S_DONE;
                        r_finish <= 1'b1;
                        r_busy   <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_finish <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase

            // Window entry; a fully clipped window goes straight to WR with the initial acc.
            if (w_enter) begin
                r_ii       <= w_nx_ii;
                r_ir_out   <= w_nx_ir_out;
                r_ic_out   <= w_nx_ic_out;
                r_ir0      <= w_nx_ir0;
                r_ic0      <= w_nx_ic0;
                r_ch_base  <= w_nx_ch_base;
                r_row_base <= w_nx_row_base;
                r_win_base <= w_nx_win_base;
                r_elem_row <= w_nx_win_base;
                r_kr_eff   <= w_kr_eff;
                r_kc_eff   <= w_kc_eff;
                r_ikr      <= '0;
                r_ikc      <= '0;
                if (w_empty) begin
                    r_state   <= S_WR;
                    r_wea     <= 1'b1;
                    r_memaddr <= w_nx_out;
                    r_wdata   <= ACC_INIT;
                end else begin
                    r_state   <= S_RD;
                    r_wea     <= 1'b0;
                    r_memaddr <= w_nx_win_base;
                end
            end
        end
    end

    assign memaddr           = r_memaddr;
    assign mem_wdata         = r_wdata;
    assign wea               = r_wea;
    assign busy              = r_busy;
    assign mp_picture_finish = r_finish;
endmodule

// File: tb/tb_maxpool_engine.sv
// Bench for maxpool_engine: BRAM model with synchronous read, and a loop-based
// reference that derives expected writes and finish cycle from the descriptor.
module tb_maxpool_engine;
    localparam int W    = 8;
    localparam int AB   = 20;
    localparam int MASK = (1 << AB) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          mp_start;
    logic [AB-1:0] mp_di, mp_dr, mp_dc, mp_dkr, mp_dkc;
    logic [2:0]    mp_step;
    logic [AB-1:0] mp_di_out, mp_dr_out, mp_dc_out, mp_inaddr, mp_outaddr;
    logic [W-1:0]  mem_rdata;
    logic [AB-1:0] memaddr;
    logic [W-1:0]  mem_wdata;
    logic          wea, busy, mp_picture_finish;

    logic [W-1:0]  mem [0:(1<<AB)-1];

    int checks   = 0;
    int failures = 0;
    int d_di, d_dr, d_dc, d_dkr, d_dkc, d_step, d_di_out, d_dr_out, d_dc_out, d_in, d_out;
    int exp_addr[$];
    int exp_data[$];
    int exp_fin;
    int got_addr[$];
    int got_data[$];

    maxpool_engine #(.width(W), .memaddrbit(AB)) dut (
        .clk(clk), .rst(rst), .mp_start(mp_start),
        .mp_di(mp_di), .mp_dr(mp_dr), .mp_dc(mp_dc), .mp_dkr(mp_dkr), .mp_dkc(mp_dkc),
        .mp_step(mp_step), .mp_di_out(mp_di_out), .mp_dr_out(mp_dr_out),
        .mp_dc_out(mp_dc_out), .mp_inaddr(mp_inaddr), .mp_outaddr(mp_outaddr),
        .mem_rdata(mem_rdata), .memaddr(memaddr), .mem_wdata(mem_wdata), .wea(wea),
        .busy(busy), .mp_picture_finish(mp_picture_finish)
    );

    always #5 clk = ~clk;

    always @(posedge clk) mem_rdata <= mem[memaddr];

    task automatic set_desc(input int di, input int dr, input int dc, input int dkr,
                            input int dkc, input int step, input int di_o, input int dr_o,
                            input int dc_o, input int ia, input int oa);
        d_di = di; d_dr = dr; d_dc = dc; d_dkr = dkr; d_dkc = dkc; d_step = step;
        d_di_out = di_o; d_dr_out = dr_o; d_dc_out = dc_o; d_in = ia; d_out = oa;
    endtask

    task automatic drive_desc();
        mp_di = AB'(d_di);   mp_dr = AB'(d_dr);   mp_dc = AB'(d_dc);
        mp_dkr = AB'(d_dkr); mp_dkc = AB'(d_dkc); mp_step = 3'(d_step);
        mp_di_out = AB'(d_di_out); mp_dr_out = AB'(d_dr_out); mp_dc_out = AB'(d_dc_out);
        mp_inaddr = AB'(d_in); mp_outaddr = AB'(d_out);
    endtask

    task automatic scramble();
        mp_di = AB'($urandom); mp_dr = AB'($urandom); mp_dc = AB'($urandom);
        mp_dkr = AB'($urandom); mp_dkc = AB'($urandom); mp_step = 3'($urandom);
        mp_di_out = AB'($urandom); mp_dr_out = AB'($urandom); mp_dc_out = AB'($urandom);
        mp_inaddr = AB'($urandom); mp_outaddr = AB'($urandom);
    endtask

    task automatic fill_random();
        for (int i = 0; i < d_di * d_dr * d_dc; i++)
            mem[(d_in + i) & MASK] = W'($urandom);
    endtask

    // Reference: plain nested loops over outputs and window elements.
    task automatic build_model();
        int oa, k, mx, ir, ic, a;
        logic signed [W-1:0] sv;
        exp_addr.delete();
        exp_data.delete();
        exp_fin = 1;
        if (d_di == 0 || d_di_out == 0 || d_dr_out == 0 || d_dc_out == 0 ||
            d_dkr == 0 || d_dkc == 0)
            return;
        oa = d_out;
        for (int ii = 0; ii < d_di_out; ii++)
            for (int ro = 0; ro < d_dr_out; ro++)
                for (int co = 0; co < d_dc_out; co++) begin
                    mx = -128;
                    k  = 0;
                    for (int kr = 0; kr < d_dkr; kr++)
                        for (int kc = 0; kc < d_dkc; kc++) begin
                            ir = ro * d_step + kr;
                            ic = co * d_step + kc;
                            if (ir < d_dr && ic < d_dc) begin
                                a  = (d_in + ii * d_dr * d_dc + ir * d_dc + ic) & MASK;
                                sv = mem[a];
                                if (sv > mx) mx = sv;
                                k++;
                            end
                        end
                    exp_addr.push_back(oa & MASK);
                    exp_data.push_back(mx & 255);
                    exp_fin += 2 * k + 1;
                    oa++;
                end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        mp_start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic run_op(input string name, input bit repulse);
        int cyc, fin_cyc, fin_cnt, busy_err, n;
        build_model();
        got_addr.delete();
        got_data.delete();
        fin_cyc  = -1;
        fin_cnt  = 0;
        busy_err = 0;
        @(negedge clk);
        drive_desc();
        mp_start = 1'b1;
        cyc = 0;
        while (cyc < exp_fin + 3) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                mp_start = 1'b0;
                scramble();
            end
            if (repulse && cyc == 3) mp_start = 1'b1;
            if (repulse && cyc == 4) mp_start = 1'b0;
            if (wea) begin
                got_addr.push_back(int'(memaddr));
                got_data.push_back(int'(mem_wdata));
            end
            if (mp_picture_finish) begin
                fin_cnt++;
                if (fin_cyc < 0) fin_cyc = cyc;
            end
            if (busy !== (cyc < exp_fin)) busy_err++;
        end
        checks++;
        if (got_addr.size() != exp_addr.size()) begin
            failures++;
            $display("FAIL %s write_count: got %0d expected %0d", name, got_addr.size(), exp_addr.size());
        end
        n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got_addr[i] != exp_addr[i]) begin
                failures++;
                $display("FAIL %s write%0d_addr: got %0d expected %0d", name, i, got_addr[i], exp_addr[i]);
            end
            checks++;
            if (got_data[i] != exp_data[i]) begin
                failures++;
                $display("FAIL %s write%0d_data: got 0x%02h expected 0x%02h", name, i, got_data[i], exp_data[i]);
            end
        end
        checks++;
        if (fin_cyc != exp_fin) begin
            failures++;
            $display("FAIL %s finish_cycle: got %0d expected %0d", name, fin_cyc, exp_fin);
        end
        checks++;
        if (fin_cnt != 1) begin
            failures++;
            $display("FAIL %s finish_pulses: got %0d expected 1", name, fin_cnt);
        end
        checks++;
        if (busy_err != 0) begin
            failures++;
            $display("FAIL %s busy_profile: got %0d bad cycles expected 0", name, busy_err);
        end
        if (fin_cyc != exp_fin) do_reset();
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (wea !== 1'b0 || busy !== 1'b0 || mp_picture_finish !== 1'b0 ||
            memaddr !== '0 || mem_wdata !== '0) begin
            failures++;
            $display("FAIL %s outputs: got wea=%b busy=%b fin=%b addr=%0d wdata=0x%02h expected all 0",
                     name, wea, busy, mp_picture_finish, memaddr, mem_wdata);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        mp_start = 1'b0;
        set_desc(1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0);
        drive_desc();
        #2;
        check_idle_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset_release");
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 16; i++) mem[100 + i] = W'(i);
    endtask

    task automatic test_basic();
        load_ramp();
        set_desc(1, 4, 4, 2, 2, 2, 1, 2, 2, 100, 200);
        run_op("basic", 1'b0);
    endtask

    task automatic test_signed();
        mem[300] = 8'hFD; mem[301] = 8'hF9; mem[302] = 8'hFF; mem[303] = 8'h80;
        set_desc(1, 2, 2, 2, 2, 2, 1, 1, 1, 300, 310);
        run_op("signed_neg", 1'b0);
        for (int i = 0; i < 4; i++) mem[320 + i] = 8'h80;
        set_desc(1, 2, 2, 2, 2, 2, 1, 1, 1, 320, 330);
        run_op("signed_all80", 1'b0);
    endtask

    task automatic test_layer1();
        set_desc(16, 30, 30, 2, 2, 2, 16, 15, 15, 3506, 17906);
        fill_random();
        run_op("layer1", 1'b0);
    endtask

    task automatic test_clipping();
        set_desc(1, 5, 5, 2, 2, 2, 1, 3, 3, 50, 400);
        fill_random();
        run_op("clip_5x5", 1'b0);
        set_desc(1, 0, 4, 2, 2, 2, 1, 1, 2, 50, 450);
        run_op("clip_empty", 1'b0);
    endtask

    task automatic test_degenerate();
        set_desc(1, 4, 4, 2, 2, 2, 1, 2, 0, 100, 500);
        run_op("degenerate", 1'b0);
    endtask

    task automatic test_robust();
        int cyc;
        load_ramp();
        set_desc(1, 4, 4, 2, 2, 2, 1, 2, 2, 100, 200);
        @(negedge clk);
        drive_desc();
        mp_start = 1'b1;
        cyc = 0;
        while (cyc < 9) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) mp_start = 1'b0;
            if (cyc == 3) mp_start = 1'b1;
            if (cyc == 4) mp_start = 1'b0;
        end
        checks++;
        if (wea !== 1'b1 || memaddr !== AB'(200) || mem_wdata !== 8'd5) begin
            failures++;
            $display("FAIL robust_first_write: got wea=%b addr=%0d data=%0d expected 1/200/5",
                     wea, memaddr, mem_wdata);
        end
        #1;
        rst = 1'b0;
        #1;
        check_idle_outputs("robust_async_reset");
        @(negedge clk);
        rst = 1'b1;
        run_op("robust_restart", 1'b1);
    endtask

    task automatic test_random();
        int di;
        for (int t = 0; t < 6; t++) begin
            di = $urandom_range(1, 3);
            set_desc(di, $urandom_range(1, 8), $urandom_range(1, 8), $urandom_range(1, 3),
                     $urandom_range(1, 3), $urandom_range(1, 3), di, $urandom_range(1, 4),
                     $urandom_range(1, 4), $urandom_range(0, 2000), $urandom_range(5000, 6000));
            fill_random();
            run_op($sformatf("random%0d", t), t[0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_clipping();
        test_degenerate();
        test_robust();
        test_random();
        test_layer1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
